// File: rtl/counter_game_pkg.sv
// counter_game_pkg: shared types and constants for the counter game.
//   ctrl_e   - count command encoding carried on the control input
//   state_e  - game phase (PLAY while counting, OVER for one cycle)
//   WHO_*    - game result encodings driven on WHO
//   CNT_W / TALLY_W / TALLY_MAX - datapath widths and tally ceiling
package counter_game_pkg;

  localparam int CNT_W     = 2;
  localparam int TALLY_W   = 4;
  localparam int TALLY_MAX = 15;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } ctrl_e;

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_e;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_WIN  = 2'b01;
  localparam logic [1:0] WHO_LOSE = 2'b10;

endpackage

// File: rtl/counter_game_if.sv
// counter_game_if: command and status bundle of the counter game.
//   control, INIT, load_value   - count command / parallel load (master -> slave)
//   WINNER, LOSER, GAMEOVER, WHO - registered game flags        (slave -> master)
//   main_counter, winner_count, loser_count - observation of internal state
interface counter_game_if;
  import counter_game_pkg::*;

  logic [1:0]         control;
  logic               INIT;
  logic [CNT_W-1:0]   load_value;
  logic               WINNER;
  logic               LOSER;
  logic               GAMEOVER;
  logic [1:0]         WHO;
  logic [CNT_W-1:0]   main_counter;
  logic [TALLY_W-1:0] winner_count;
  logic [TALLY_W-1:0] loser_count;

  modport master (
    output control, INIT, load_value,
    input  WINNER, LOSER, GAMEOVER, WHO, main_counter, winner_count, loser_count
  );

  modport slave (
    input  control, INIT, load_value,
    output WINNER, LOSER, GAMEOVER, WHO, main_counter, winner_count, loser_count
  );

endinterface

// File: rtl/counter_game_tally.sv
// game_tally: event tally that stops at TALLY_MAX and flags the increment
// that will reach it.
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - count one event this cycle
//   clr       - synchronous clear (wins over inc)
//   count     - current tally
//   full_next - this cycle's increment takes the tally from 14 to 15
module game_tally
  import counter_game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [TALLY_W-1:0] count,
  output logic               full_next
);

  localparam logic [TALLY_W-1:0] TOP = TALLY_W'(TALLY_MAX);
  localparam logic [TALLY_W-1:0] PRE = TALLY_W'(TALLY_MAX - 1);

  logic [TALLY_W-1:0] count_q, count_d;

  // Next tally: clear first, otherwise count up but never past the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != TOP)) begin
      count_d = count_q + 4'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Tally register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign full_next = inc && (count_q == PRE);

endmodule

// File: rtl/counter_game.sv
// counter_game: 2-bit up/down counter game. Landing on 3 is a win, landing
// on 0 is a loss; the first tally to reach 15 ends the game for one cycle,
// after which everything restarts from zero.
//   clk - clock (rising edge)
//   rst - asynchronous active-high reset
//   bus - counter_game_if.slave: commands in, registered flags and state out
module counter_game
  import counter_game_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  counter_game_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_TOP = 2'd3;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] step_s;
  logic             winner_q, winner_d;
  logic             loser_q, loser_d;
  logic             gameover_q, gameover_d;
  logic [1:0]       who_q, who_d;
  logic             win_inc_s, lose_inc_s, tally_clr_s;
  logic             win_full_s, lose_full_s;
  logic [TALLY_W-1:0] win_cnt_s, lose_cnt_s;

  // Step to add modulo 4; a decrement is the two's-complement addend.
  always_comb begin
    step_s = 2'd0;
    case (ctrl_e'(bus.control))
      UP1:     step_s = 2'd1;
      UP2:     step_s = 2'd2;
      DN1:     step_s = 2'd3;
      DN2:     step_s = 2'd2;
      default: step_s = 2'd0;
    endcase
  end

  // Counter datapath and win/lose event detection.
  always_comb begin
    cnt_d       = cnt_q;
    winner_d    = 1'b0;
    loser_d     = 1'b0;
    win_inc_s   = 1'b0;
    lose_inc_s  = 1'b0;
    tally_clr_s = 1'b0;
    case (state_q)
      PLAY: begin
        if (bus.INIT) begin
          cnt_d = bus.load_value;
        end else begin
          cnt_d = cnt_q + step_s;
        end
        winner_d   = (cnt_d == CNT_TOP);
        loser_d    = (cnt_d == 2'd0);
        win_inc_s  = winner_d;
        lose_inc_s = loser_d;
      end
      OVER: begin
        // Restart clear: not a loss event even though the counter becomes 0.
        cnt_d       = 2'd0;
        tally_clr_s = 1'b1;
      end
      default: begin
        cnt_d       = 2'd0;
        tally_clr_s = 1'b1;
      end
    endcase
  end

  // Phase sequencing and game result; kept apart from the datapath block
  // because it depends on the tallies' full_next, which depend on the incs.
  always_comb begin
    state_d    = state_q;
    gameover_d = 1'b0;
    who_d      = WHO_NONE;
    case (state_q)
      PLAY: begin
        if (win_full_s) begin
          gameover_d = 1'b1;
          who_d      = WHO_WIN;
          state_d    = OVER;
        end else if (lose_full_s) begin
          gameover_d = 1'b1;
          who_d      = WHO_LOSE;
          state_d    = OVER;
        end else begin
          state_d = PLAY;
        end
      end
      OVER:    state_d = PLAY;
      default: state_d = PLAY;
    endcase
  end

  // State, counter and output flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PLAY;
      cnt_q      <= 2'd0;
      winner_q   <= 1'b0;
      loser_q    <= 1'b0;
      gameover_q <= 1'b0;
      who_q      <= WHO_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      winner_q   <= winner_d;
      loser_q    <= loser_d;
      gameover_q <= gameover_d;
      who_q      <= who_d;
    end
  end

  game_tally u_win_tally (
    .clk       (clk),
    .rst       (rst),
    .inc       (win_inc_s),
    .clr       (tally_clr_s),
    .count     (win_cnt_s),
    .full_next (win_full_s)
  );

  game_tally u_lose_tally (
    .clk       (clk),
    .rst       (rst),
    .inc       (lose_inc_s),
    .clr       (tally_clr_s),
    .count     (lose_cnt_s),
    .full_next (lose_full_s)
  );

  assign bus.WINNER       = winner_q;
  assign bus.LOSER        = loser_q;
  assign bus.GAMEOVER     = gameover_q;
  assign bus.WHO          = who_q;
  assign bus.main_counter = cnt_q;
  assign bus.winner_count = win_cnt_s;
  assign bus.loser_count  = lose_cnt_s;

endmodule

// File: doc/counter_game.md
COUNTER_GAME -- requirements
Module: counter_game

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port control, input, 2: count command; 00 = +1, 01 = +2, 10 = -1, 11 = -2.
REQ-004 SHALL have port INIT, input, 1: when high, the counter loads load_value instead of counting.
REQ-005 SHALL have port load_value, input, 2: parallel load value.
REQ-006 SHALL have port WINNER, output, 1: registered flag; the counter has just become 3.
REQ-007 SHALL have port LOSER, output, 1: registered flag; the counter has just become 0.
REQ-008 SHALL have port GAMEOVER, output, 1: registered one-cycle pulse; a tally has reached 15.
REQ-009 SHALL have port WHO, output, 2: game result; 00 = none, 01 = winner tally full, 10 = loser tally full, 11 = never driven.
REQ-010 SHALL have observation ports main_counter (output, 2), winner_count (output, 4) and loser_count (output, 4), which directly reflect internal state.

Function
REQ-011 States SHALL be PLAY and OVER; the reset state is PLAY.
REQ-012 In PLAY, next counter SHALL be load_value when INIT=1 (INIT has priority over control), else counter + or - the step given by control, modulo 4: 3+1=0, 3+2=1, 0-1=3, 1-2=3.
REQ-013 In PLAY, WINNER SHALL be 1 in the cycle after any edge where next counter == 3, including loads of 3; otherwise 0.
REQ-014 In PLAY, LOSER SHALL be 1 in the cycle after any edge where next counter == 0, including loads of 0 and wraps to 0; otherwise 0.
REQ-015 WINNER and LOSER are mutually exclusive by construction; the bench SHALL flag any cycle in which both are 1.
REQ-016 winner_count SHALL increment on the same edge that sets WINNER, and loser_count on the same edge that sets LOSER; neither increments at any other time.
REQ-017 When an increment takes a tally from 14 to 15, on that same edge GAMEOVER SHALL be set to 1, WHO SHALL be set to 01 (winner) or 10 (loser), and the state SHALL go to OVER.
REQ-018 In OVER (exactly one cycle), control and INIT SHALL be ignored.
REQ-019 On the edge leaving OVER, main_counter, winner_count and loser_count SHALL all clear to 0.
REQ-020 On the edge leaving OVER, GAMEOVER, WINNER, LOSER and WHO SHALL clear to 0.
REQ-021 On the edge leaving OVER, the state SHALL return to PLAY.
REQ-022 The clear to 0 on leaving OVER SHALL NOT count as a loser event.
REQ-023 Outside the one OVER cycle, WHO SHALL be 00 and GAMEOVER SHALL be 0.
REQ-024 Tallies SHALL never exceed 15 and SHALL never wrap.
REQ-025 Latency from control or INIT sampled to a flag SHALL be exactly one clock.

Reset
REQ-026 While rst=1, asynchronously and regardless of clk: state=PLAY, main_counter=0, winner_count=0, loser_count=0, WINNER=0, LOSER=0, GAMEOVER=0, WHO=00.
REQ-027 Reset SHALL NOT raise LOSER even though the counter is 0.
REQ-028 Reset asserted during OVER SHALL abort the game; the first edge after reset release SHALL be normal PLAY.

Structure
REQ-029 Package counter_game_pkg SHALL hold:
- control encoding enum (UP1, UP2, DN1, DN2);
- WHO encoding constants (WHO_NONE, WHO_WIN, WHO_LOSE);
- state enum (PLAY, OVER);
- CNT_W=2, TALLY_W=4, TALLY_MAX=15.
REQ-030 Sub-module game_tally SHALL be a 4-bit saturating-detect counter with ports clk, rst, inc, clr, count and full_next (full_next = inc and count==14), instantiated once for winners and once for losers.

Verification
REQ-031 Reset release, then control=00 for 3 cycles -> main_counter 1,2,3; WINNER=1 in the third result cycle only; winner_count=1.
REQ-032 INIT=1, load_value=2, control=11 -> main_counter=2 with no flags; next cycle INIT=0, control=11 -> main_counter=0, LOSER=1, loser_count=1.
REQ-033 Counter=3, control=00 -> counter=0, LOSER=1; counter=1, control=11 -> counter=3, WINNER=1 (wrap both directions).
REQ-034 Drive 15 winner events (e.g. alternate INIT load_value=3 and load_value=1) -> on the 15th: GAMEOVER=1, WHO=01 for exactly one cycle; next cycle all counts 0, WHO=00; control during OVER has no effect.
REQ-035 Same with 15 loser events -> WHO=10; assert rst mid-game with winner_count=7 -> all outputs 0 immediately, without waiting for a clk edge.
